// File: rtl/fifo_uart_pkg.sv
// Shared UART definitions: TX state encoding, line levels and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int DEFAULT_DATA_W       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick is high during the terminal count.
// Latency: tick follows the counter register combinationally; restart clears it on the next edge.
// Backpressure: none, free-running unless restarted.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count one bit period, wrapping at the terminal count or on an explicit restart.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == TERMINAL) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == TERMINAL);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a registered-read FIFO and serialises them as UART frames (start, LSB-first data, [parity], stop).
// Latency: empty seen low at cycle N -> pop strobe at N+1 -> start bit on tx at N+3; 3 idle cycles between frames.
// Backpressure: pops only when the FIFO is non-empty and the line is idle; FIFO_UART_TX_PARITY_EN adds an even-parity bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_enable,
  output logic              tx,
  output logic              busy
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              tx_d;
  logic              tick;
  logic              restart;

`ifdef FIFO_UART_TX_PARITY_EN
  logic par_q;
`endif

  // Every state entry starts a fresh bit period.
  assign restart = (state_d != state_q);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // State, shifter and registered outputs; outputs are decoded from next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      shreg_q          <= '0;
      bit_q            <= '0;
      tx               <= UART_IDLE_LEVEL;
      fifo_read_enable <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state_q          <= state_d;
      shreg_q          <= shreg_d;
      bit_q            <= bit_d;
      tx               <= tx_d;
      fifo_read_enable <= (state_d == FETCH);
      busy             <= (state_d != IDLE);
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Even parity of the word, taken from the same FIFO data the shifter loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (state_q == LOAD) begin
      par_q <= ^fifo_data;
    end
  end
`endif

  // Next-state, shifter/bit-count update and line level for the coming cycle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    tx_d    = UART_IDLE_LEVEL;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO read data is valid the cycle after the pop strobe.
        shreg_d = fifo_data;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_DATA_BIT) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        // The bit counter is reused to count stop bits.
        if (tick) begin
          if (bit_q == LAST_STOP_BIT) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a registered-read FIFO model.
// Latency: frames checked cycle by cycle against expected line levels.
// Backpressure: FIFO model flags any pop while empty.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_enable;
  logic       tx;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  int depth   = 0;
  int pops    = 0;
  int bad_pop = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (depth == 0);

  fifo_uart_tx #(
    .DATA_W      (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .fifo_read_enable(fifo_read_enable),
    .tx              (tx),
    .busy            (busy)
  );

  // Registered-read FIFO model.
  always @(posedge clk) begin
    if (fifo_read_enable) begin
      if (depth == 0) begin
        bad_pop <= bad_pop + 1;
      end else begin
        fifo_data <= q.pop_front();
        depth     <= depth - 1;
        pops      <= pops + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    depth = depth + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance until tx falls (bounded); n is the number of cycles waited.
  task automatic wait_fall(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 200);
    check({tag, "_start_seen"}, {31'b0, tx}, 32'd0);
  endtask

  // Called on the first start-bit cycle; checks every cycle of the frame.
  task automatic frame(input string tag, input logic [7:0] b, input logic par);
    int nb;
    int k;
    int lvl_err;
    int busy_err;
    int pop_err;
    logic e;
    logic [7:0] dec;
    nb = 1 + 8 + P + 1;
    lvl_err = 0;
    busy_err = 0;
    pop_err = 0;
    dec = 8'h00;
    for (int i = 0; i < nb * CPB; i++) begin
      if (i > 0) @(negedge clk);
      k = i / CPB;
      if (k == 0) e = 1'b0;
      else if (k <= 8) e = b[k-1];
      else if (P == 1 && k == 9) e = par;
      else e = 1'b1;
      if (tx !== e) lvl_err++;
      if (busy !== 1'b1) busy_err++;
      if (fifo_read_enable !== 1'b0) pop_err++;
      if (k >= 1 && k <= 8 && (i % CPB) == CPB / 2) dec[k-1] = tx;
    end
    check({tag, "_byte"}, {24'b0, dec}, {24'b0, b});
    check({tag, "_levels"}, lvl_err, 0);
    check({tag, "_busy"}, busy_err, 0);
    check({tag, "_nopop"}, pop_err, 0);
  endtask

  initial begin
    int n;
    int bad;
    int p0;

    // Reset with a word already waiting.
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_pop", {31'b0, fifo_read_enable}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("pop_lat", {31'b0, fifo_read_enable}, 32'd1);
    check("fetch_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("pop_pulse", {31'b0, fifo_read_enable}, 32'd0);
    check("load_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("start_lat", {31'b0, tx}, 32'd0);
    frame("a5", 8'hA5, 1'b0);
    @(negedge clk);
    check("a5_busy_off", {31'b0, busy}, 32'd0);
    check("a5_pops", pops, 1);

    // Three back-to-back words.
    push(8'hCC);
    push(8'h33);
    push(8'h0F);
    wait_fall("cc", n);
    frame("cc", 8'hCC, ^8'hCC);
    wait_fall("33", n);
    check("gap1", n - 1, 3);
    frame("33", 8'h33, ^8'h33);
    wait_fall("0f", n);
    check("gap2", n - 1, 3);
    frame("0f", 8'h0F, ^8'h0F);
    @(negedge clk);
    check("burst_busy_off", {31'b0, busy}, 32'd0);
    check("burst_pops", pops, 4);

    // Empty FIFO: line stays quiet.
    bad = 0;
    p0 = pops;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_enable !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_pops", pops, p0);

    // Reset in the middle of the data bits of 8'hFF.
    push(8'hFF);
    wait_fall("ff", n);
    repeat (14) @(negedge clk);
    check("ff_mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    push(8'h11);
    @(negedge clk);
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_pop", {31'b0, fifo_read_enable}, 32'd0);
    rst = 1'b0;
    wait_fall("11", n);
    check("restart_lat", n, 3);
    frame("11", 8'h11, ^8'h11);
    @(negedge clk);
    check("total_pops", pops, 6);
    check("fifo_drained", depth, 0);

`ifdef FIFO_UART_TX_PARITY_EN
    push(8'h07);
    push(8'h03);
    wait_fall("p07", n);
    frame("p07", 8'h07, 1'b1);
    wait_fall("p03", n);
    check("pgap", n - 1, 3);
    frame("p03", 8'h03, 1'b0);
    @(negedge clk);
    check("par_pops", pops, 8);
`endif

    check("no_pop_when_empty", bad_pop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the synchronous FIFO: pops one word at a time and serialises it as an asynchronous UART frame (start, data LSB-first, optional parity, stop).
- Drives the FIFO's read_enable.
- Samples the FIFO's data_out and empty.
- Sits between the FIFO and the chip's serial TX pin.

Parameters:
- DATA_W, 8, data bits per frame; equals the FIFO word width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after read_enable is high (registered read).
- fifo_read_enable  out  1  one-cycle pop strobe to the FIFO.
- tx  out  1  serial line, idle high.
- busy  out  1  high from the pop strobe through the last stop-bit cycle.

Behaviour:
- Reset values: tx=1, fifo_read_enable=0, busy=0, state=IDLE, bit and baud counters=0.
- All outputs are registered. rst mid-frame aborts the frame immediately:
  - tx returns high next cycle.
  - The partially sent word is discarded, not re-popped.
- FSM states and transitions:
  - IDLE: tx=1. If fifo_empty=0 -> FETCH.
  - FETCH: fifo_read_enable=1 for exactly this one cycle. Unconditionally -> LOAD.
  - LOAD: shift_reg <= fifo_data. -> START.
  - START: tx=0 for CLKS_PER_BIT cycles. -> DATA.
  - DATA: tx=shift_reg[0]; shift right every CLKS_PER_BIT cycles. After DATA_W bits -> PARITY if enabled, else STOP.
  - PARITY: see Optional Feature. -> STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. -> IDLE.
- Latency:
  - fifo_empty sampled low in IDLE at cycle N -> fifo_read_enable high in N+1 -> tx falls in N+3.
  - Frame length is (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 if parity is enabled, else 0.
  - Minimum gap between back-to-back frames: 3 idle-high cycles (IDLE, FETCH, LOAD).
- Baud counter runs 0..CLKS_PER_BIT-1 and resets on every state entry. Bit counter is $clog2(DATA_W+1) wide.
- Handshake rules:
  - fifo_read_enable is never asserted while fifo_empty=1.
  - At most one pop per frame; no pop outside FETCH.
- Boundary cases:
  - fifo_empty rising during a frame has no effect on the current frame.
  - FIFO write concurrent with our pop is the FIFO's concern; the block relies only on empty/data timing.
- busy is 1 in FETCH through STOP and 0 in IDLE.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state is present and emits one bit for CLKS_PER_BIT cycles.
  - Parity bit is the even parity of the word (XOR of all DATA_W bits), captured in LOAD.
  - Frame length gains one bit time.
- Undefined:
  - No PARITY state, no parity register.
  - DATA goes directly to STOP.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - tx_state_e enum (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP).
  - UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0.
  - Default DATA_W and CLKS_PER_BIT localparams.
- One sub-module: baud_tick_gen.
  - Counter 0..CLKS_PER_BIT-1 with a restart input; emits a one-cycle tick at terminal count.
  - Reused by the future RX block.

Test Plan (CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1, behavioural FIFO model):
- Reset held 3 cycles with FIFO non-empty -> tx=1, fifo_read_enable=0, busy=0 throughout; no pop until 1 cycle after rst falls.
- Push 8'hA5 -> exactly one pop pulse; tx shows 0 for 4 cycles, then 1,0,1,0,0,1,0,1, then stop 1; total frame 40 cycles. Decoded byte must equal 8'hA5.
- Push 8'hCC, 8'h33, 8'h0F back-to-back -> three frames in order; 3 idle-high cycles between frames; 3 pops total; busy deasserts only after the third stop bit.
- FIFO empty for 50 cycles -> no pops, tx constant 1, busy=0.
- Assert rst mid-DATA of 8'hFF -> tx=1 the next cycle, state IDLE; the next FIFO word 8'h11 is sent intact and 8'hFF is not resent.
- FIFO_UART_TX_PARITY_EN defined, push 8'h07 -> parity bit 1, frame 44 cycles; push 8'h03 -> parity bit 0.
